// File: rtl/de0_timeset.sv
// de0_timeset: time-setting controller for the DE0 clock display.
// Two raw push-buttons are synchronised and debounced into one-cycle press
// pulses. A three-state mode machine (run / set minutes / set seconds) turns
// INC presses into minute-increment or seconds-clear pulses, gates the 1 Hz
// count enable, and blinks the digits under edit.
module de0_timeset #(
  parameter logic [19:0] DEBOUNCE   = 20'd1_000_000,
  parameter logic [24:0] BLINK_HALF = 25'd25_000_000
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       nBTN_MODE,
  input  logic       nBTN_INC,
  input  logic       EN1HZ,
  output logic       RUN,
  output logic       SECEN,
  output logic       MININC,
  output logic       SECCLR,
  output logic [3:0] BLANK,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    RUN_ST  = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2
  } state_t;

  // Button channels: bit 0 = MODE, bit 1 = INC. All levels active-low.
  logic [1:0]  raw;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  stable;
  logic [1:0]  press;
  logic [1:0]  deb_done;
  logic [19:0] dcnt [2];

  state_t      state_q;
  state_t      state_d;
  logic        mininc_d;
  logic        secclr_d;

  logic [24:0] bcnt;
  logic        phase;

  assign raw = {nBTN_INC, nBTN_MODE};

  // Debounce terminal condition: levels still differ after DEBOUNCE-1 counts.
  always_comb begin
    deb_done = '0;
    for (int i = 0; i < 2; i++) begin
      deb_done[i] = (sync2[i] != stable[i]) && (dcnt[i] == DEBOUNCE - 20'd1);
    end
  end

  // Synchroniser, debounce counters, stable levels and registered press pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      stable <= 2'b11;
      press  <= 2'b00;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          dcnt[i]  <= '0;
          press[i] <= 1'b0;
        end else if (deb_done[i]) begin
          // Accept the new level; only the 1->0 (press) direction is an event.
          stable[i] <= sync2[i];
          dcnt[i]   <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          dcnt[i]  <= dcnt[i] + 20'd1;
          press[i] <= 1'b0;
        end
      end
    end
  end

  // Mode state register and registered edit pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN_ST;
      MININC  <= 1'b0;
      SECCLR  <= 1'b0;
    end else begin
      state_q <= state_d;
      MININC  <= mininc_d;
      SECCLR  <= secclr_d;
    end
  end

  // Next state and edit decisions; a MODE press wins over a coincident INC press.
  always_comb begin
    state_d  = state_q;
    mininc_d = 1'b0;
    secclr_d = 1'b0;
    if (press[0]) begin
      case (state_q)
        RUN_ST:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN_ST;
      endcase
    end else if (press[1]) begin
      case (state_q)
        SET_MIN: mininc_d = 1'b1;
        SET_SEC: secclr_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Blink timer: free-running half-period counter, restarted on every mode change
  // so a freshly selected field always starts visible.
  always_ff @(posedge CLK) begin
    if (!nRST || (state_d != state_q)) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLINK_HALF - 25'd1) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 25'd1;
    end
  end

  // Status outputs, count enable and digit blanking.
  always_comb begin
    RUN       = (state_q == RUN_ST);
    SECEN     = EN1HZ & RUN;
    DBG_STATE = state_q;
    case (state_q)
      SET_MIN: BLANK = {phase, phase, 2'b00};
      SET_SEC: BLANK = {2'b00, phase, phase};
      default: BLANK = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_de0_timeset.sv
// Bench for de0_timeset with short debounce and blink periods. A behavioural
// model tracks raw button history, run lengths of disagreeing samples, the
// mode sequence and the time since the last mode change; outputs are compared
// on every falling edge, plus scenario-level pulse counts.
module tb_de0_timeset;

  localparam int DEB = 4;
  localparam int BH  = 8;

  logic       clk;
  logic       nrst;
  logic       btn_mode;
  logic       btn_inc;
  logic       en1hz;
  logic       run;
  logic       secen;
  logic       mininc;
  logic       secclr;
  logic [3:0] blank;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int cnt_mininc = 0;
  int cnt_secclr = 0;
  int cnt_secen  = 0;
  int cnt_en     = 0;

  // Model state
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_stable [2];
  int m_run [2];
  bit m_press [2];
  int m_state;
  bit m_mininc;
  bit m_secclr;
  int m_since;

  de0_timeset #(
    .DEBOUNCE  (20'd4),
    .BLINK_HALF(25'd8)
  ) dut (
    .CLK      (clk),
    .nRST     (nrst),
    .nBTN_MODE(btn_mode),
    .nBTN_INC (btn_inc),
    .EN1HZ    (en1hz),
    .RUN      (run),
    .SECEN    (secen),
    .MININC   (mininc),
    .SECCLR   (secclr),
    .BLANK    (blank),
    .DBG_STATE(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model advanced once per rising edge using pre-edge inputs.
  task automatic model_edge();
    bit raw [2];
    bit old_press [2];
    int old_state;
    raw[0] = btn_mode;
    raw[1] = btn_inc;
    if (!nrst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_stable[b] = 1; m_run[b] = 0; m_press[b] = 0;
      end
      m_state = 0; m_mininc = 0; m_secclr = 0; m_since = 0;
    end else begin
      old_press[0] = m_press[0];
      old_press[1] = m_press[1];
      old_state    = m_state;
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_stable[b] = m_s2[b];
            m_run[b]    = 0;
            m_press[b]  = (m_s2[b] == 0);
          end else begin
            m_press[b] = 0;
          end
        end else begin
          m_run[b]   = 0;
          m_press[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      if (old_press[0]) begin
        m_state  = (m_state + 1) % 3;
        m_mininc = 0;
        m_secclr = 0;
      end else begin
        m_mininc = old_press[1] && (old_state == 1);
        m_secclr = old_press[1] && (old_state == 2);
      end
      if (m_state != old_state) m_since = 0;
      else m_since++;
    end
  endtask

  task automatic check_outputs();
    bit p;
    logic [3:0] exp_blank;
    p = ((m_since / BH) % 2) == 1;
    case (m_state)
      1:       exp_blank = {p, p, 2'b00};
      2:       exp_blank = {2'b00, p, p};
      default: exp_blank = 4'b0000;
    endcase
    chk("run",    run,       (m_state == 0));
    chk("secen",  secen,     en1hz && (m_state == 0));
    chk("mininc", mininc,    m_mininc);
    chk("secclr", secclr,    m_secclr);
    chk("blank",  blank,     exp_blank);
    chk("state",  dbg_state, m_state);
    chk("excl",   mininc & secclr, 1'b0);
    if (mininc) cnt_mininc++;
    if (secclr) cnt_secclr++;
    if (secen)  cnt_secen++;
    if (en1hz)  cnt_en++;
  endtask

  // One clock: random 1 Hz tick, edge, model update, check at falling edge.
  task automatic tick();
    en1hz = ($urandom_range(0, 2) == 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    cnt_mininc = 0; cnt_secclr = 0; cnt_secen = 0; cnt_en = 0;
  endtask

  // which: 0 = MODE, 1 = INC, 2 = both together
  task automatic push(input int which, input int n);
    if (which != 1) btn_mode = 1'b0;
    if (which != 0) btn_inc  = 1'b0;
    idle(n);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    idle(12);
  endtask

  initial begin
    int hold_m;
    int hold_i;
    nrst     = 1'b0;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    en1hz    = 1'b0;
    @(negedge clk);

    // Reset and run mode
    idle(3);
    nrst = 1'b1;
    clr_counts();
    idle(20);
    chk("run_secen_count", cnt_secen, cnt_en);

    // Enter SET_MIN, watch blink
    push(0, 10);
    idle(24);
    chk("setmin_state", dbg_state, 2'd1);

    // Short INC glitch, then a real press
    clr_counts();
    push(1, 3);
    chk("glitch_mininc", cnt_mininc, 0);
    clr_counts();
    push(1, 10);
    chk("press_mininc", cnt_mininc, 1);
    chk("press_secclr", cnt_secclr, 0);

    // SET_SEC: clear seconds, no count enable
    push(0, 10);
    idle(20);
    clr_counts();
    push(1, 10);
    chk("setsec_secclr", cnt_secclr, 1);
    chk("setsec_mininc", cnt_mininc, 0);
    chk("setsec_secen",  cnt_secen,  0);

    // Back to RUN_ST; INC ignored
    push(0, 10);
    chk("run_state", dbg_state, 2'd0);
    clr_counts();
    push(1, 10);
    chk("run_inc_mininc", cnt_mininc, 0);
    chk("run_inc_secclr", cnt_secclr, 0);

    // MODE and INC together in SET_MIN
    push(0, 10);
    clr_counts();
    push(2, 10);
    chk("both_state",  dbg_state, 2'd2);
    chk("both_mininc", cnt_mininc, 0);
    chk("both_secclr", cnt_secclr, 0);

    // Reset during SET_MIN with INC debounce in progress
    push(0, 10);
    push(0, 10);
    chk("pre_rst_state", dbg_state, 2'd1);
    clr_counts();
    btn_inc = 1'b0;
    idle(4);
    nrst = 1'b0;
    idle(2);
    btn_inc = 1'b1;
    nrst = 1'b1;
    idle(12);
    chk("rst_mininc", cnt_mininc, 0);
    chk("rst_state",  dbg_state, 2'd0);
    chk("rst_blank",  blank, 4'b0000);

    // Random buttons with occasional reset
    hold_m = 0;
    hold_i = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_m == 0) begin
        btn_mode = $urandom_range(0, 1);
        hold_m   = $urandom_range(1, 12);
      end
      if (hold_i == 0) begin
        btn_inc = $urandom_range(0, 1);
        hold_i  = $urandom_range(1, 12);
      end
      hold_m--;
      hold_i--;
      nrst = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de0_timeset.md
DE0_TIMESET -- requirements
Module: de0_timeset

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 20'd1_000_000; consecutive stable cycles (20 ms at 50 MHz) before a button level is accepted.
REQ-002 SHALL have parameter BLINK_HALF, default 25'd25_000_000; cycles per blink half-period (0.5 s at 50 MHz).
REQ-003 SHALL have port CLK  input  1  50 MHz system clock; all flops rising-edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port nBTN_MODE  input  1  raw DE0 push-button, active-low, asynchronous to CLK.
REQ-006 SHALL have port nBTN_INC  input  1  raw DE0 push-button, active-low, asynchronous to CLK.
REQ-007 SHALL have port EN1HZ  input  1  one-cycle 1 Hz tick from the 1-second divider.
REQ-008 SHALL have port RUN  output  1  high when the clock counts normally.
REQ-009 SHALL have port SECEN  output  1  EN1HZ & RUN, combinational; count enable to the seconds counter.
REQ-010 SHALL have port MININC  output  1  one-cycle increment pulse to the minutes counter.
REQ-011 SHALL have port SECCLR  output  1  one-cycle clear pulse to the seconds counter.
REQ-012 SHALL have port BLANK  output  4  per-digit blank mask, bit n blanks nSEGn, 1 = blank.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each button SHALL have a debounce counter: increments each cycle synced level != stable level, clears to 0 when equal; when it reaches DEBOUNCE-1 and levels still differ, stable level SHALL update at the next edge and counter SHALL clear.
REQ-015 A press event SHALL be a registered one-cycle pulse, asserted on the same edge the stable level goes 1->0; release (0->1) SHALL produce no event.
REQ-016 Glitches shorter than DEBOUNCE cycles SHALL produce no event and no stable-level change.
REQ-017 FSM states SHALL be RUN_ST, SET_MIN, SET_SEC; transitions only on MODE press: RUN_ST->SET_MIN->SET_SEC->RUN_ST.
REQ-018 RUN SHALL be 1 in RUN_ST, 0 otherwise; SECEN SHALL therefore be 0 throughout set modes.
REQ-019 In SET_MIN an INC press SHALL produce MININC=1 for exactly one cycle, on the edge after the press pulse.
REQ-020 In SET_SEC an INC press SHALL produce SECCLR=1 for exactly one cycle, on the edge after the press pulse.
REQ-021 In RUN_ST INC presses SHALL be ignored (no MININC, no SECCLR).
REQ-022 MODE and INC press in the same cycle: MODE transition SHALL be taken, INC discarded.
REQ-023 Blink counter SHALL count 0..BLINK_HALF-1, toggle blink phase on wrap, and clear (counter 0, phase 0) on every state change.
REQ-024 BLANK SHALL be 4'b0000 in RUN_ST, {phase,phase,2'b00} in SET_MIN, {2'b00,phase,phase} in SET_SEC; phase 0 = digits visible.
REQ-025 MININC and SECCLR SHALL never both be 1 in the same cycle.

Reset
REQ-026 While nRST=0 at a rising edge: state SHALL be RUN_ST, RUN=1, MININC=0, SECCLR=0, BLANK=4'b0000.
REQ-027 Reset SHALL set synchronizer flops and stable levels to 1 (released) and clear debounce and blink counters and phase.
REQ-028 Reset asserted mid-debounce or mid-set-mode SHALL discard pending events; held buttons after reset SHALL require a full DEBOUNCE period before a press is recognised.

Verification (DEBOUNCE=4, BLINK_HALF=8)
REQ-029 Reset, EN1HZ pulsed -> RUN=1, SECEN follows EN1HZ, BLANK=0000, MININC=SECCLR=0.
REQ-030 nBTN_INC low 3 cycles then high, in SET_MIN -> no MININC; held low 10 cycles -> exactly one MININC pulse.
REQ-031 Three MODE presses -> states SET_MIN (RUN=0, BLANK toggles 1100/0000 every 8 cycles), SET_SEC (BLANK 0011/0000), RUN_ST (BLANK 0000, RUN=1).
REQ-032 SET_SEC, one INC press -> SECCLR one cycle, MININC stays 0; EN1HZ pulses meanwhile -> SECEN=0.
REQ-033 MODE and INC stable-low on same cycle in SET_MIN -> move to SET_SEC, no MININC, no SECCLR.
REQ-034 nRST low during SET_MIN with INC debounce in progress -> RUN=1, BLANK=0000, no MININC after release of reset.
